axil_regbank: RTL

AXIL_REGBANK -- requirements
Module: axil_regbank

---
 rtl/axil_regbank_pkg.sv | 12 +
 rtl/axil_regbank_if.sv | 33 +++
 rtl/axil_regbank_wr_ctrl.sv | 68 ++++++
 rtl/axil_regbank.sv | 56 +++++
 4 files changed

// File: rtl/axil_regbank_pkg.sv
// axil_regbank_pkg: response codes and FSM states; AXIL_REGBANK_SLVERR_EN selects SLVERR for out-of-range accesses
package axil_regbank_pkg;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
`ifdef AXIL_REGBANK_SLVERR_EN
  localparam logic [1:0] RESP_OOR = RESP_SLVERR;
`else
  localparam logic [1:0] RESP_OOR = RESP_OKAY;
`endif
  typedef enum logic [1:0] {W_IDLE, W_HAVE_A, W_HAVE_D, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;
endpackage

// File: rtl/axil_regbank_if.sv
// axil_regbank_if: AXI4-Lite bus bundle with master/slave views
interface axil_regbank_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
);
  logic [ADDR_W-1:0] AWADDR;
  logic [2:0] AWPROT;
  logic AWVALID;
  logic AWREADY;
  logic [DATA_W-1:0] WDATA;
  logic [DATA_W/8-1:0] WSTRB;
  logic WVALID;
  logic WREADY;
  logic [1:0] BRESP;
  logic BVALID;
  logic BREADY;
  logic [ADDR_W-1:0] ARADDR;
  logic [2:0] ARPROT;
  logic ARVALID;
  logic ARREADY;
  logic [DATA_W-1:0] RDATA;
  logic [1:0] RRESP;
  logic RVALID;
  logic RREADY;
  modport master (
    output AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARPROT, ARVALID, RREADY,
    input AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );
  modport slave (
    input AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARPROT, ARVALID, RREADY,
    output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );
endinterface

// File: rtl/axil_regbank_wr_ctrl.sv
// axil_regbank_wr_ctrl: write channel FSM, register storage with byte-strobe merge and commit pulses
module axil_regbank_wr_ctrl
  import axil_regbank_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8,
  parameter int NUM_REGS = 4
) (
  input logic ACLK,
  input logic ARESET,
  axil_regbank_if.slave bus,
  output logic [NUM_REGS-1:0][DATA_W-1:0] regs,
  output logic [NUM_REGS-1:0] wr_pulse
);
  localparam int LSB = $clog2(DATA_W / 8);
  localparam int IW = $clog2(NUM_REGS);
  w_state_t state, nxt;
  logic [ADDR_W-1:0] addr_q, addr;
  logic [DATA_W-1:0] data_q, data;
  logic [DATA_W/8-1:0] strb_q, strb;
  logic aw_hs, w_hs, commit, in_rng;
  logic [IW-1:0] idx;
  // next state and the effective address/data of a commit, taking whichever half arrives this cycle
  always_comb begin
    aw_hs = bus.AWVALID & bus.AWREADY;
    w_hs = bus.WVALID & bus.WREADY;
    nxt = state == W_IDLE ? (aw_hs && w_hs ? W_RESP : aw_hs ? W_HAVE_A : w_hs ? W_HAVE_D : W_IDLE)
        : state == W_HAVE_A ? (w_hs ? W_RESP : W_HAVE_A)
        : state == W_HAVE_D ? (aw_hs ? W_RESP : W_HAVE_D)
        : (bus.BREADY ? W_IDLE : W_RESP);
    commit = state != W_RESP && nxt == W_RESP;
    addr = aw_hs ? bus.AWADDR : addr_q;
    data = w_hs ? bus.WDATA : data_q;
    strb = w_hs ? bus.WSTRB : strb_q;
    idx = addr[LSB +: IW];
    in_rng = (addr >> (LSB + IW)) == '0;
  end
  // state, registered handshake outputs, capture of early halves, and strobed register update
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state <= W_IDLE;
      addr_q <= '0;
      data_q <= '0;
      strb_q <= '0;
      regs <= '0;
      wr_pulse <= '0;
      bus.AWREADY <= 1'b0;
      bus.WREADY <= 1'b0;
      bus.BVALID <= 1'b0;
      bus.BRESP <= RESP_OKAY;
    end else begin
      state <= nxt;
      bus.AWREADY <= nxt == W_IDLE || nxt == W_HAVE_D;
      bus.WREADY <= nxt == W_IDLE || nxt == W_HAVE_A;
      bus.BVALID <= nxt == W_RESP;
      if (aw_hs) addr_q <= bus.AWADDR;
      if (w_hs) begin
        data_q <= bus.WDATA;
        strb_q <= bus.WSTRB;
      end
      if (commit) bus.BRESP <= in_rng ? RESP_OKAY : RESP_OOR;
      wr_pulse <= commit && in_rng ? NUM_REGS'(1) << idx : '0;
      for (int k = 0; k < NUM_REGS; k++)
        for (int b = 0; b < DATA_W / 8; b++)
          if (commit && in_rng && idx == IW'(k) && strb[b]) regs[k][b*8 +: 8] <= data[b*8 +: 8];
    end
  end
endmodule

// File: rtl/axil_regbank.sv
// axil_regbank: AXI4-Lite register bank; AXIL_REGBANK_SLVERR_EN makes out-of-range accesses answer SLVERR
module axil_regbank
  import axil_regbank_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8,
  parameter int NUM_REGS = 4
) (
  input logic ACLK,
  input logic ARESET,
  axil_regbank_if.slave bus,
  output logic [NUM_REGS*DATA_W-1:0] reg_q,
  output logic [NUM_REGS-1:0] wr_pulse
);
  localparam int LSB = $clog2(DATA_W / 8);
  localparam int IW = $clog2(NUM_REGS);
  logic [NUM_REGS-1:0][DATA_W-1:0] regs;
  r_state_t r_state, r_nxt;
  logic ar_hs, ar_in;
  logic [IW-1:0] ar_idx;
  logic unused_prot;
  axil_regbank_wr_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS)) u_wr (
    .ACLK(ACLK),
    .ARESET(ARESET),
    .bus(bus),
    .regs(regs),
    .wr_pulse(wr_pulse)
  );
  assign reg_q = regs;
  assign unused_prot = ^{bus.AWPROT, bus.ARPROT};
  // read FSM next state and address decode
  always_comb begin
    ar_hs = bus.ARVALID & bus.ARREADY;
    r_nxt = r_state == R_IDLE ? (ar_hs ? R_DATA : R_IDLE) : (bus.RREADY ? R_IDLE : R_DATA);
    ar_idx = bus.ARADDR[LSB +: IW];
    ar_in = (bus.ARADDR >> (LSB + IW)) == '0;
  end
  // read channel: data is captured at the AR handshake, so a same-edge write is not yet visible
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_state <= R_IDLE;
      bus.ARREADY <= 1'b0;
      bus.RVALID <= 1'b0;
      bus.RDATA <= '0;
      bus.RRESP <= RESP_OKAY;
    end else begin
      r_state <= r_nxt;
      bus.ARREADY <= r_nxt == R_IDLE;
      bus.RVALID <= r_nxt == R_DATA;
      if (ar_hs) begin
        bus.RDATA <= ar_in ? regs[ar_idx] : '0;
        bus.RRESP <= ar_in ? RESP_OKAY : RESP_OOR;
      end
    end
  end
endmodule
